pulse_stretcher_multi: RTL and testbench

PULSE_STRETCHER_MULTI -- requirements
Module: pulse_stretcher_multi

---
 rtl/pulse_stretcher_pkg.sv | 12 +
 rtl/pulse_stretcher_chan.sv | 87 ++++++++
 rtl/pulse_stretcher_multi.sv | 40 ++++
 tb/tb_pulse_stretcher_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the multi-channel pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RETRIG  = 1'b1;

endpackage

// File: rtl/pulse_stretcher_chan.sv
// One stretcher channel: idle/hold FSM with a down-counting length timer
// and a sticky overrun flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | output low, waiting for a trigger
//   ST_HOLD | output high, timer counts remaining cycles down to zero
module pulse_stretcher_chan
    import pulse_stretcher_pkg::*;
#(
    parameter int par_T_stretch_bits = 7,
    parameter int par_edge_detect    = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_x,
    input  logic [par_T_stretch_bits-1:0] i_len,
    input  logic                          i_retrig,
    input  logic                          i_ovr_clr,
    output logic                          o_y,
    output logic                          o_ovr
);

    localparam logic [par_T_stretch_bits-1:0] TIMER_ONE  = par_T_stretch_bits'(1);
    localparam logic [par_T_stretch_bits-1:0] TIMER_ZERO = '0;

    state_t                          state_q;
    logic [par_T_stretch_bits-1:0]   timer_q;
    logic                            y_q;
    logic                            ovr_q;
    logic                            x_prev_q;

    logic                            trig;
    logic [par_T_stretch_bits-1:0]   load_val;

    assign trig     = (par_edge_detect != 0) ? (i_x & ~x_prev_q) : i_x;
    // A zero length still produces a single-cycle pulse.
    assign load_val = (i_len == TIMER_ZERO) ? TIMER_ZERO : (i_len - TIMER_ONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= TIMER_ZERO;
            y_q      <= 1'b0;
            ovr_q    <= 1'b0;
            x_prev_q <= 1'b0;
        end else begin
            x_prev_q <= i_x;
            if (i_ovr_clr) begin
                ovr_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_q <= ST_HOLD;
                        timer_q <= load_val;
                        y_q     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (trig && (i_retrig == MODE_RETRIG)) begin
                        timer_q <= load_val;
                    end else begin
                        // Later assignment lets a fresh overrun beat a coincident clear.
                        if (trig) begin
                            ovr_q <= 1'b1;
                        end
                        if (timer_q == TIMER_ZERO) begin
                            state_q <= ST_IDLE;
                            y_q     <= 1'b0;
                        end else begin
                            timer_q <= timer_q - TIMER_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    y_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_y   = y_q;
    assign o_ovr = ovr_q;

endmodule

// File: rtl/pulse_stretcher_multi.sv
// Bank of independent pulse stretcher channels sharing length and mode;
// the top only adds the combined busy indication.
module pulse_stretcher_multi
    import pulse_stretcher_pkg::*;
#(
    parameter int par_channels       = 4,
    parameter int par_T_stretch_bits = 7,
    parameter int par_edge_detect    = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [par_channels-1:0]       i_x,
    input  logic [par_T_stretch_bits-1:0] i_len,
    input  logic                          i_retrig,
    input  logic                          i_ovr_clr,
    output logic [par_channels-1:0]       o_y,
    output logic [par_channels-1:0]       o_ovr,
    output logic                          o_busy
);

    for (genvar g = 0; g < par_channels; g++) begin : g_chan
        pulse_stretcher_chan #(
            .par_T_stretch_bits (par_T_stretch_bits),
            .par_edge_detect    (par_edge_detect)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_x       (i_x[g]),
            .i_len     (i_len),
            .i_retrig  (i_retrig),
            .i_ovr_clr (i_ovr_clr),
            .o_y       (o_y[g]),
            .o_ovr     (o_ovr[g])
        );
    end

    // Built from registered outputs, so async reset clears it immediately.
    assign o_busy = |o_y;

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Scoreboard bench: a level-trigger and an edge-trigger instance share stimulus
// and are compared against an interval-based reference model.
module tb_pulse_stretcher_multi;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_x = '0;
    logic [6:0] i_len = '0;
    logic       i_retrig = 1'b0;
    logic       i_ovr_clr = 1'b0;

    logic [3:0] y_l, ovr_l, y_e, ovr_e;
    logic       busy_l, busy_e;

    always #5 clk = ~clk;

    pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_bits(7), .par_edge_detect(0)) dut_lvl (
        .i_clk(clk), .i_rst(i_rst), .i_x(i_x), .i_len(i_len), .i_retrig(i_retrig),
        .i_ovr_clr(i_ovr_clr), .o_y(y_l), .o_ovr(ovr_l), .o_busy(busy_l)
    );

    pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_bits(7), .par_edge_detect(1)) dut_edg (
        .i_clk(clk), .i_rst(i_rst), .i_x(i_x), .i_len(i_len), .i_retrig(i_retrig),
        .i_ovr_clr(i_ovr_clr), .o_y(y_e), .o_ovr(ovr_e), .o_busy(busy_e)
    );

    typedef struct {
        logic [3:0] y0;
        logic [3:0] o0;
        logic       b0;
        logic [3:0] y1;
        logic [3:0] o1;
        logic       b1;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // Model: a pulse is the interval of edges after which the output is high,
    // ending at edge bu; the channel still owns the edge right after it.
    int  bu   [2][4];
    bit  ovr_m[2][4];
    bit  xp   [2][4];
    int  kk = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 4; n++) begin
                bu[m][n]    = -100;
                ovr_m[m][n] = 1'b0;
                xp[m][n]    = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [3:0] x, input int len, input bit rt, input bit clr, input bit rs);
        exp_t e;
        int   l_eff;
        bit   trig, hold, ov;
        logic [3:0] yv[2];
        logic [3:0] ov_v[2];
        @(negedge clk);
        i_x = x; i_len = 7'(len); i_retrig = rt; i_ovr_clr = clr; i_rst = rs;
        kk++;
        l_eff = (len == 0) ? 1 : len;
        if (rs) model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 4; n++) begin
                if (!rs) begin
                    trig = (m == 1) ? (x[n] && !xp[m][n]) : x[n];
                    xp[m][n] = x[n];
                    hold = (kk <= bu[m][n] + 1);
                    ov = 1'b0;
                    if (trig) begin
                        if (!hold || rt) bu[m][n] = kk + l_eff - 1;
                        else ov = 1'b1;
                    end
                    ovr_m[m][n] = (ovr_m[m][n] && !clr) || ov;
                end
                yv[m][n]   = (kk <= bu[m][n]);
                ov_v[m][n] = ovr_m[m][n];
            end
        end
        e.y0 = yv[0]; e.o0 = ov_v[0]; e.b0 = |yv[0];
        e.y1 = yv[1]; e.o1 = ov_v[1]; e.b1 = |yv[1];
        q.push_back(e);
    endtask

    task automatic idle(input int n, input int len, input bit rt);
        repeat (n) step(4'b0000, len, rt, 1'b0, 1'b0);
    endtask

    task automatic async_rst();
        @(posedge clk);
        #3;
        i_rst = 1'b1;
        #1;
        check("async_rst y_lvl", y_l, 4'b0000);
        check("async_rst busy_lvl", {3'b000, busy_l}, 4'b0000);
        check("async_rst y_edg", y_e, 4'b0000);
        check("async_rst busy_edg", {3'b000, busy_e}, 4'b0000);
        check("async_rst ovr_lvl", ovr_l, 4'b0000);
        model_reset();
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("y_lvl", y_l, e.y0);
                check("ovr_lvl", ovr_l, e.o0);
                check("busy_lvl", {3'b000, busy_l}, {3'b000, e.b0});
                check("y_edg", y_e, e.y1);
                check("ovr_edg", ovr_e, e.o1);
                check("busy_edg", {3'b000, busy_e}, {3'b000, e.b1});
            end
        end
    end

    initial begin
        logic [3:0] xr;
        bit         rtr;
        int         lr, r;
        model_reset();
        repeat (3) step(4'b0000, 5, 1'b0, 1'b0, 1'b1);
        idle(2, 5, 1'b0);

        // single short trigger, one-shot
        step(4'b0001, 5, 1'b0, 1'b0, 1'b0);
        idle(8, 5, 1'b0);

        // one-shot overrun, then clear
        step(4'b0010, 5, 1'b0, 1'b0, 1'b0);
        idle(2, 5, 1'b0);
        step(4'b0010, 5, 1'b0, 1'b0, 1'b0);
        idle(6, 5, 1'b0);
        step(4'b0000, 5, 1'b0, 1'b1, 1'b0);
        idle(2, 5, 1'b0);

        // retrigger extends the pulse
        step(4'b0100, 5, 1'b1, 1'b0, 1'b0);
        idle(2, 5, 1'b1);
        step(4'b0100, 5, 1'b1, 1'b0, 1'b0);
        idle(8, 5, 1'b1);

        // length boundaries and mid-pulse length change
        step(4'b0001, 0, 1'b0, 1'b0, 1'b0);
        idle(3, 0, 1'b0);
        step(4'b0001, 127, 1'b0, 1'b0, 1'b0);
        idle(5, 127, 1'b0);
        idle(125, 3, 1'b0);
        idle(3, 3, 1'b0);

        // held trigger: repeated pulses in level mode, single pulse in edge mode
        repeat (20) step(4'b1000, 4, 1'b0, 1'b0, 1'b0);
        idle(6, 4, 1'b0);

        // overrun coincident with clear keeps the flag
        step(4'b0010, 3, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 3, 1'b0, 1'b1, 1'b0);
        idle(5, 3, 1'b0);

        // async reset mid-pulse; trigger held across release
        step(4'b0001, 10, 1'b0, 1'b0, 1'b0);
        idle(3, 10, 1'b0);
        async_rst();
        repeat (2) step(4'b1000, 5, 1'b0, 1'b0, 1'b1);
        repeat (4) step(4'b1000, 5, 1'b0, 1'b0, 1'b0);
        idle(12, 5, 1'b0);

        xr = '0;
        rtr = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) != 0)
                xr = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            r = $urandom_range(0, 19);
            lr = (r < 18) ? $urandom_range(0, 8) : ((r == 18) ? 127 : $urandom_range(100, 127));
            if ($urandom_range(0, 15) == 0) rtr = ~rtr;
            if (i == 350) begin
                async_rst();
                step(xr, lr, rtr, 1'b0, 1'b1);
            end else begin
                step(xr, lr, rtr, ($urandom_range(0, 15) == 0), 1'b0);
            end
        end
        idle(4, 5, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 4'(q.size()), 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
